// File: rtl/serial_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_exec_unit
// Purpose  : RV32I execute stage (ADD/SUB/shifts/ADDI/LUI/BEQ/BNE) with a
//            1-bit-per-cycle serial shifter and a registered result port.
// Revision : 1.0 - initial release
// ============================================================================
module serial_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    output logic            out_valid,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target,
    output logic            illegal
);

    localparam logic [4:0] c_OPC_OP     = 5'b01100;
    localparam logic [4:0] c_OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] c_OPC_BRANCH = 5'b11000;
    localparam logic [4:0] c_OPC_LUI    = 5'b01101;
    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_SHIFT   = 1'b1;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [4:0]      w_opc;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_lui_value;
    logic            w_unused_bits;

    assign w_opc         = inst[6:2];
    assign w_funct3      = inst[14:12];
    assign w_funct7      = inst[31:25];
    assign w_rd          = inst[11:7];
    assign w_imm_i       = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign w_imm_b       = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign w_lui_value   = {inst[31:12], 12'b0};
    assign w_unused_bits = ^inst[1:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_legal;
    logic w_writes;
    logic w_is_branch;
    logic w_is_lui;
    logic w_is_shift;
    logic w_sh_left;
    logic w_sh_arith;
    logic w_alu_sub;
    logic w_use_imm;

    always_comb begin
        w_legal     = 1'b0;
        w_writes    = 1'b0;
        w_is_branch = 1'b0;
        w_is_lui    = 1'b0;
        w_is_shift  = 1'b0;
        w_sh_left   = 1'b0;
        w_sh_arith  = 1'b0;
        w_alu_sub   = 1'b0;
        w_use_imm   = 1'b0;
        case (w_opc)
            c_OPC_OP: begin
                case (w_funct3)
                    3'b000: begin
                        if (w_funct7 == c_F7_BASE) begin
                            w_legal  = 1'b1;
                            w_writes = 1'b1;
                        end else if (w_funct7 == c_F7_ALT) begin
                            w_legal   = 1'b1;
                            w_writes  = 1'b1;
                            w_alu_sub = 1'b1;
                        end
                    end
                    3'b001: begin
                        if (w_funct7 == c_F7_BASE) begin
                            w_legal    = 1'b1;
                            w_writes   = 1'b1;
                            w_is_shift = 1'b1;
                            w_sh_left  = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (w_funct7 == c_F7_BASE || w_funct7 == c_F7_ALT) begin
                            w_legal    = 1'b1;
                            w_writes   = 1'b1;
                            w_is_shift = 1'b1;
                            w_sh_arith = (w_funct7 == c_F7_ALT);
                        end
                    end
                    default: ;
                endcase
            end
            c_OPC_OP_IMM: begin
                case (w_funct3)
                    3'b000: begin
                        w_legal   = 1'b1;
                        w_writes  = 1'b1;
                        w_use_imm = 1'b1;
                    end
                    3'b001: begin
                        if (w_funct7 == c_F7_BASE) begin
                            w_legal    = 1'b1;
                            w_writes   = 1'b1;
                            w_is_shift = 1'b1;
                            w_sh_left  = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (w_funct7 == c_F7_BASE || w_funct7 == c_F7_ALT) begin
                            w_legal    = 1'b1;
                            w_writes   = 1'b1;
                            w_is_shift = 1'b1;
                            w_sh_arith = (w_funct7 == c_F7_ALT);
                        end
                    end
                    default: ;
                endcase
            end
            c_OPC_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001) begin
                    w_legal     = 1'b1;
                    w_is_branch = 1'b1;
                end
            end
            c_OPC_LUI: begin
                w_legal  = 1'b1;
                w_writes = 1'b1;
                w_is_lui = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_operand_b;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_alu_result;
    logic [XLEN-1:0] w_br_target;
    logic            w_br_cond;

    assign w_shamt      = (w_opc == c_OPC_OP_IMM) ? inst[24:20] : rs2_data[4:0];
    assign w_operand_b  = w_use_imm ? w_imm_i : rs2_data;
    assign w_sum        = w_alu_sub ? (rs1_data - w_operand_b) : (rs1_data + w_operand_b);
    // A zero-amount shift completes in one cycle and simply passes rs1 through.
    assign w_alu_result = w_is_lui ? w_lui_value : (w_is_shift ? rs1_data : w_sum);
    assign w_br_target  = pc + w_imm_b;
    assign w_br_cond    = w_funct3[0] ? (rs1_data != rs2_data) : (rs1_data == rs2_data);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [4:0] r_count;
    logic       w_accept;
    logic       w_start_shift;
    logic       w_shift_done;

    assign w_accept      = in_valid && in_ready;
    assign w_start_shift = w_accept && w_legal && w_is_shift && (w_shamt != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (kill) begin
            w_state_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (w_start_shift)    w_state_next = c_ST_SHIFT;
                c_ST_SHIFT: if (r_count == 5'd1)  w_state_next = c_ST_IDLE;
                default:                          w_state_next = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready     = (r_state == c_ST_IDLE) && !kill;
        w_shift_done = (r_state == c_ST_SHIFT) && (r_count == 5'd1) && !kill;
    end

    // ------------------------------------------------------------------
    // Serial shifter
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_shreg;
    logic [XLEN-1:0] w_shreg_next;
    logic            r_sh_left;
    logic            r_sh_arith;
    logic [4:0]      r_sh_rd;

    // For SRA the MSB never changes, so it always holds the original sign.
    assign w_shreg_next = r_sh_left ? {r_shreg[XLEN-2:0], 1'b0}
                                    : {r_sh_arith & r_shreg[XLEN-1], r_shreg[XLEN-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg    <= '0;
            r_count    <= 5'd0;
            r_sh_left  <= 1'b0;
            r_sh_arith <= 1'b0;
            r_sh_rd    <= 5'd0;
        end else if (kill) begin
            r_count <= 5'd0;
        end else if (w_start_shift) begin
            r_shreg    <= rs1_data;
            r_count    <= w_shamt;
            r_sh_left  <= w_sh_left;
            r_sh_arith <= w_sh_arith;
            r_sh_rd    <= w_rd;
        end else if (r_state == c_ST_SHIFT) begin
            r_shreg <= w_shreg_next;
            r_count <= r_count - 5'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic            r_rd_we;
    logic [4:0]      r_rd_addr;
    logic [XLEN-1:0] r_rd_data;
    logic            r_br_taken;
    logic [XLEN-1:0] r_br_target;
    logic            r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_rd_we     <= 1'b0;
            r_rd_addr   <= 5'd0;
            r_rd_data   <= '0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_rd_we     <= 1'b0;
            r_br_taken  <= 1'b0;
            r_illegal   <= 1'b0;
            if (w_shift_done) begin
                r_out_valid <= 1'b1;
                r_rd_we     <= (r_sh_rd != 5'd0);
                r_rd_addr   <= r_sh_rd;
                r_rd_data   <= w_shreg_next;
            end else if (w_accept && !w_start_shift) begin
                r_out_valid <= 1'b1;
                if (!w_legal) begin
                    r_illegal <= 1'b1;
                end else if (w_is_branch) begin
                    r_br_taken  <= w_br_cond;
                    r_br_target <= w_br_target;
                end else begin
                    r_rd_we   <= w_writes && (w_rd != 5'd0);
                    r_rd_addr <= w_rd;
                    r_rd_data <= w_alu_result;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign rd_we     = r_rd_we;
    assign rd_addr   = r_rd_addr;
    assign rd_data   = r_rd_data;
    assign br_taken  = r_br_taken;
    assign br_target = r_br_target;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_serial_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_exec_unit
// Purpose  : Randomised self-checking bench for serial_exec_unit against an
//            instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        kill = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_exec_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .kill      (kill),
        .out_valid (out_valid),
        .rd_we     (rd_we),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .br_taken  (br_taken),
        .br_target (br_target),
        .illegal   (illegal)
    );

    // Reference model outputs
    int          exp_lat;
    logic        exp_wr, exp_we, exp_isbr, exp_br, exp_ill;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_tgt;

    // Observed outputs from issue()
    int          got_lat, got_busy;
    logic        got_rdy, got_we, got_br, got_ill;
    logic [4:0]  got_addr;
    logic [31:0] got_data, got_tgt;

    task automatic model(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  amt;
        logic [31:0] imm;
        logic        shift;
        f7 = i[31:25]; f3 = i[14:12]; amt = 5'd0; shift = 1'b0;
        imm = {{20{i[31]}}, i[31:20]};
        exp_wr = 1'b0; exp_isbr = 1'b0; exp_br = 1'b0; exp_ill = 1'b0;
        exp_addr = i[11:7]; exp_data = '0;
        exp_tgt = p + {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        case (i[6:2])
            5'b01100: begin
                amt = b[4:0];
                if (f3 == 3'd0 && f7 == 7'h00)      begin exp_wr = 1; exp_data = a + b; end
                else if (f3 == 3'd0 && f7 == 7'h20) begin exp_wr = 1; exp_data = a - b; end
                else if (f3 == 3'd1 && f7 == 7'h00) begin shift = 1; exp_data = a << amt; end
                else if (f3 == 3'd5 && f7 == 7'h00) begin shift = 1; exp_data = a >> amt; end
                else if (f3 == 3'd5 && f7 == 7'h20) begin shift = 1; exp_data = $unsigned($signed(a) >>> amt); end
                else exp_ill = 1;
            end
            5'b00100: begin
                amt = i[24:20];
                if (f3 == 3'd0)                     begin exp_wr = 1; exp_data = a + imm; end
                else if (f3 == 3'd1 && f7 == 7'h00) begin shift = 1; exp_data = a << amt; end
                else if (f3 == 3'd5 && f7 == 7'h00) begin shift = 1; exp_data = a >> amt; end
                else if (f3 == 3'd5 && f7 == 7'h20) begin shift = 1; exp_data = $unsigned($signed(a) >>> amt); end
                else exp_ill = 1;
            end
            5'b11000: begin
                if (f3 == 3'd0)      begin exp_isbr = 1; exp_br = (a == b); end
                else if (f3 == 3'd1) begin exp_isbr = 1; exp_br = (a != b); end
                else exp_ill = 1;
            end
            5'b01101: begin exp_wr = 1; exp_data = {i[31:12], 12'h000}; end
            default: exp_ill = 1;
        endcase
        if (shift) exp_wr = 1;
        exp_we  = exp_wr && (i[11:7] != 5'd0);
        exp_lat = (shift && amt != 5'd0) ? int'(amt) + 1 : 1;
    endtask

    function automatic logic [31:0] enc_b(input logic [12:0] bi, input logic [2:0] f3);
        return {bi[12], bi[10:5], 5'd2, 5'd1, f3, bi[4:1], bi[11], 7'b1100011};
    endfunction

    // kind: 0 add/sub, 1 addi, 2 lui, 3 branch, 4 shift reg, 5 shift imm, other illegal
    function automatic logic [31:0] rand_inst(input int kind);
        logic [4:0]  rd, r1, r2;
        logic [11:0] imm;
        logic [12:0] bi;
        int          sel;
        rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
        imm = 12'($urandom); bi = 13'($urandom) & 13'h1FFE; sel = $urandom_range(0, 4);
        case (kind)
            0: return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r2, r1, 3'b000, rd, 7'b0110011};
            1: return {imm, r1, 3'b000, rd, 7'b0010011};
            2: return {20'($urandom), rd, 7'b0110111};
            3: return {bi[12], bi[10:5], r2, r1, 2'b00, 1'($urandom), bi[4:1], bi[11], 7'b1100011};
            4, 5: begin
                logic [6:0] op7;
                op7 = (kind == 4) ? 7'b0110011 : 7'b0010011;
                case (sel % 3)
                    0:       return {7'h00, r2, r1, 3'b001, rd, op7};
                    1:       return {7'h00, r2, r1, 3'b101, rd, op7};
                    default: return {7'h20, r2, r1, 3'b101, rd, op7};
                endcase
            end
            default: begin
                case (sel)
                    0:       return {25'($urandom), 7'b0000011};
                    1:       return {7'h01, r2, r1, 3'b000, rd, 7'b0110011};
                    2:       return {7'h20, r2, r1, 3'b001, rd, 7'b0010011};
                    3:       return {7'($urandom), r2, r1, 3'($urandom_range(2, 7)), rd, 7'b1100011};
                    default: return {7'h00, r2, r1, 3'b010, rd, 7'b0110011};
                endcase
            end
        endcase
    endfunction

    // Present one instruction, then wait (bounded) for its result strobe.
    task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        got_rdy = in_ready;
        in_valid = 1'b1; inst = i; pc = p; rs1_data = a; rs2_data = b;
        @(negedge clk);
        in_valid = 1'b0; inst = $urandom; pc = $urandom; rs1_data = $urandom; rs2_data = $urandom;
        got_lat = 1; got_busy = 0;
        while (out_valid !== 1'b1 && got_lat < 64) begin
            if (in_ready === 1'b0) got_busy++;
            @(negedge clk);
            got_lat++;
        end
        got_we = rd_we; got_br = br_taken; got_ill = illegal;
        got_addr = rd_addr; got_data = rd_data; got_tgt = br_target;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, rd_we, br_taken, illegal} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b%b%b%b required 0000", out_valid, rd_we, br_taken, illegal);
        end
        checks++;
        if (rd_addr !== 5'd0 || rd_data !== 32'd0 || br_target !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%0d data=%h tgt=%h required 0", rd_addr, rd_data, br_target);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_alu();
        logic [31:0] i, a, b;
        for (int n = 0; n < 26; n++) begin
            if (n == 0)      begin i = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}; a = 32'h7FFFFFFF; b = 32'd1; end
            else if (n == 1) begin i = {7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'b0110011}; a = 32'd0; b = 32'd1; end
            else begin i = rand_inst($urandom_range(0, 2)); a = $urandom; b = $urandom; end
            model(i, 32'h0, a, b);
            issue(i, 32'h0, a, b);
            checks++;
            if (got_rdy !== 1'b1 || got_lat != exp_lat) begin
                errors++;
                $display("FAIL alu_timing: inst=%h ready=%b lat=%0d, required ready=1 lat=%0d", i, got_rdy, got_lat, exp_lat);
            end
            checks++;
            if (got_we !== exp_we || got_br !== 1'b0 || got_ill !== 1'b0 ||
                got_addr !== exp_addr || got_data !== exp_data) begin
                errors++;
                $display("FAIL alu_result: inst=%h got we=%b br=%b ill=%b rd=%0d data=%h, required we=%b br=0 ill=0 rd=%0d data=%h",
                         i, got_we, got_br, got_ill, got_addr, got_data, exp_we, exp_addr, exp_data);
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rd_we !== 1'b0) begin
            errors++;
            $display("FAIL alu_pulse: out_valid=%b rd_we=%b one cycle later, required 0 0", out_valid, rd_we);
        end
    endtask

    task automatic test_shift();
        logic [31:0] i, a, b;
        for (int n = 0; n < 22; n++) begin
            if (n == 0)      begin i = {7'h20, 5'd4, 5'd1, 3'b101, 5'd5, 7'b0010011}; a = 32'h80000010; b = $urandom; end
            else if (n == 1) begin i = {7'h00, 5'd2, 5'd1, 3'b001, 5'd6, 7'b0110011}; a = $urandom; b = 32'h20; end
            else if (n == 2) begin i = {7'h00, 5'd2, 5'd1, 3'b101, 5'd7, 7'b0110011}; a = 32'hDEADBEEF; b = 32'd31; end
            else begin i = rand_inst($urandom_range(4, 5)); a = $urandom; b = $urandom; end
            model(i, 32'h0, a, b);
            issue(i, 32'h0, a, b);
            checks++;
            if (got_rdy !== 1'b1 || got_lat != exp_lat || got_busy != exp_lat - 1) begin
                errors++;
                $display("FAIL shift_timing: inst=%h ready=%b lat=%0d busy=%0d, required ready=1 lat=%0d busy=%0d",
                         i, got_rdy, got_lat, got_busy, exp_lat, exp_lat - 1);
            end
            checks++;
            if (got_we !== exp_we || got_ill !== 1'b0 || got_addr !== exp_addr || got_data !== exp_data) begin
                errors++;
                $display("FAIL shift_result: inst=%h got we=%b ill=%b rd=%0d data=%h, required we=%b ill=0 rd=%0d data=%h",
                         i, got_we, got_ill, got_addr, got_data, exp_we, exp_addr, exp_data);
            end
            if (n == 0) begin
                checks++;
                if (got_data !== 32'hF8000001 || got_lat != 5) begin
                    errors++;
                    $display("FAIL srai_directed: data=%h lat=%0d, required F8000001 lat=5", got_data, got_lat);
                end
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0 || rd_we !== 1'b0) begin
                    errors++;
                    $display("FAIL shift_pulse: out_valid=%b rd_we=%b one cycle later, required 0 0", out_valid, rd_we);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] i, p, a, b;
        for (int n = 0; n < 16; n++) begin
            if (n == 0)      begin i = enc_b(13'h1FF8, 3'b000); p = 32'h100; a = 32'd5; b = 32'd5; end
            else if (n == 1) begin i = enc_b(13'h1FF8, 3'b001); p = 32'h100; a = 32'd5; b = 32'd5; end
            else if (n == 2) begin i = enc_b(13'h0020, 3'b001); p = 32'hFFFFFFF0; a = 32'd1; b = 32'd2; end
            else begin
                i = rand_inst(3); p = $urandom; a = $urandom;
                b = ($urandom_range(0, 1) == 1) ? a : $urandom;
            end
            model(i, p, a, b);
            issue(i, p, a, b);
            checks++;
            if (got_lat != 1 || got_we !== 1'b0 || got_ill !== 1'b0 || got_br !== exp_br || got_tgt !== exp_tgt) begin
                errors++;
                $display("FAIL branch: inst=%h lat=%0d we=%b ill=%b br=%b tgt=%h, required lat=1 we=0 ill=0 br=%b tgt=%h",
                         i, got_lat, got_we, got_ill, got_br, got_tgt, exp_br, exp_tgt);
            end
            if (n < 3) begin
                checks++;
                if (got_br !== (n == 0 || n == 2) || got_tgt !== ((n == 2) ? 32'h10 : 32'hF8)) begin
                    errors++;
                    $display("FAIL branch_directed_%0d: br=%b tgt=%h", n, got_br, got_tgt);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] i, a, b;
        for (int n = 0; n < 14; n++) begin
            i = (n == 0) ? {12'h0, 5'd1, 3'b010, 5'd4, 7'b0000011} : rand_inst(6);
            a = $urandom; b = $urandom;
            model(i, 32'h0, a, b);
            issue(i, 32'h0, a, b);
            checks++;
            if (got_lat != 1 || got_ill !== 1'b1 || got_we !== 1'b0 || got_br !== 1'b0 || exp_ill !== 1'b1) begin
                errors++;
                $display("FAIL illegal: inst=%h lat=%0d ill=%b we=%b br=%b, required lat=1 ill=1 we=0 br=0",
                         i, got_lat, got_ill, got_we, got_br);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] i, a, b;
        logic        p_we, p_wr, p_isbr, p_br, p_ill;
        logic [4:0]  p_addr;
        logic [31:0] p_data, p_tgt;
        int          nb = 12;
        p_we = 0; p_wr = 0; p_isbr = 0; p_br = 0; p_ill = 0; p_addr = 0; p_data = 0; p_tgt = 0;
        for (int k = 0; k <= nb; k++) begin
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (out_valid !== 1'b1 || rd_we !== p_we || br_taken !== p_br || illegal !== p_ill ||
                    (p_wr && (rd_addr !== p_addr || rd_data !== p_data)) || (p_isbr && br_target !== p_tgt)) begin
                    errors++;
                    $display("FAIL b2b_%0d: v=%b we=%b br=%b ill=%b rd=%0d data=%h tgt=%h, required v=1 we=%b br=%b ill=%b rd=%0d data=%h tgt=%h",
                             k - 1, out_valid, rd_we, br_taken, illegal, rd_addr, rd_data, br_target,
                             p_we, p_br, p_ill, p_addr, p_data, p_tgt);
                end
            end
            if (k == 1) begin
                checks++;
                if (rd_data !== 32'hABCDE000 || rd_we !== 1'b1 || rd_addr !== 5'd1) begin
                    errors++;
                    $display("FAIL b2b_lui: data=%h we=%b rd=%0d, required ABCDE000 1 1", rd_data, rd_we, rd_addr);
                end
            end
            if (k < nb) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_%0d: got %b required 1", k, in_ready);
                end
                if (k == 0)      i = {20'hABCDE, 5'd1, 7'b0110111};
                else if (k == 1) i = {12'h123, 5'd1, 3'b000, 5'd0, 7'b0010011};
                else begin
                    int kind;
                    kind = $urandom_range(0, 4);
                    i = rand_inst((kind == 4) ? 6 : kind);
                end
                a = $urandom; b = $urandom;
                model(i, 32'h40, a, b);
                in_valid = 1'b1; inst = i; pc = 32'h40; rs1_data = a; rs2_data = b;
                p_we = exp_we; p_wr = exp_wr; p_isbr = exp_isbr; p_br = exp_br; p_ill = exp_ill;
                p_addr = exp_addr; p_data = exp_data; p_tgt = exp_tgt;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_kill();
        logic seen;
        for (int s = 0; s < 2; s++) begin
            // s=0: SRL by 31 killed in cycle 10; s=1: SRL by 3 killed on its final shift cycle
            @(negedge clk);
            in_valid = 1'b1; inst = {7'h00, 5'd2, 5'd1, 3'b101, 5'd7, 7'b0110011};
            rs1_data = 32'hFFFF0000; rs2_data = (s == 0) ? 32'd31 : 32'd3;
            @(negedge clk);
            in_valid = 1'b0;
            repeat ((s == 0) ? 9 : 2) @(negedge clk);
            kill = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL kill_ready_low_%0d: got %b required 0", s, in_ready);
            end
            @(negedge clk);
            kill = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL kill_after_%0d: out_valid=%b in_ready=%b, required 0 1", s, out_valid, in_ready);
            end
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (out_valid !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen !== 1'b0) begin
                errors++;
                $display("FAIL kill_no_result_%0d: out_valid seen=%b required 0", s, seen);
            end
        end
        // kill in IDLE with a valid instruction present: nothing is accepted
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; inst = {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_ready: got %b required 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_accept: out_valid seen=%b required 0", seen);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        issue(enc_b(13'h0040, 3'b000), 32'h1000, 32'd9, 32'd9);
        issue({7'h00, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011}, 32'h0, 32'h1234, 32'h1);
        @(negedge clk);
        in_valid = 1'b1; inst = {7'h20, 5'd2, 5'd1, 3'b101, 5'd8, 7'b0110011};
        rs1_data = 32'h80000000; rs2_data = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, rd_we, br_taken, illegal} !== 4'b0000 || rd_addr !== 5'd0 ||
            rd_data !== 32'd0 || br_target !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_shift: v=%b we=%b br=%b ill=%b rd=%0d data=%h tgt=%h rdy=%b, required all 0 and rdy=1",
                     out_valid, rd_we, br_taken, illegal, rd_addr, rd_data, br_target, in_ready);
        end
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: out_valid seen=%b required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] i, p, a, b;
        for (int n = 0; n < 40; n++) begin
            i = rand_inst($urandom_range(0, 6));
            p = $urandom; a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            model(i, p, a, b);
            issue(i, p, a, b);
            checks++;
            if (got_rdy !== 1'b1 || got_lat != exp_lat || got_we !== exp_we || got_br !== exp_br ||
                got_ill !== exp_ill || (exp_wr && (got_addr !== exp_addr || got_data !== exp_data)) ||
                (exp_isbr && got_tgt !== exp_tgt)) begin
                errors++;
                $display("FAIL random_%0d: inst=%h lat=%0d we=%b br=%b ill=%b rd=%0d data=%h tgt=%h, required lat=%0d we=%b br=%b ill=%b rd=%0d data=%h tgt=%h",
                         n, i, got_lat, got_we, got_br, got_ill, got_addr, got_data, got_tgt,
                         exp_lat, exp_we, exp_br, exp_ill, exp_addr, exp_data, exp_tgt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_shift();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_kill();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
